// File: rtl/axi_snoop_cnt_regs.sv
// Passive AXI4 handshake counter with an AXI4 config port for readout and control.

package axi_snoop_cnt_regs_pkg;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } axi_ax_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
    } axi_w_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } axi_b_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_rsp_t;

endpackage

module axi_snoop_cnt_regs #(
    parameter int unsigned AxiIdWidth = 4,
    parameter type axi_req_t = axi_snoop_cnt_regs_pkg::axi_req_t,
    parameter type axi_rsp_t = axi_snoop_cnt_regs_pkg::axi_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  axi_req_t snoop_req_i,
    input  axi_rsp_t snoop_rsp_i,
    output axi_req_t snoop_req_o,
    output axi_rsp_t snoop_rsp_o,
    input  axi_req_t cfg_req_i,
    output axi_rsp_t cfg_rsp_o
);

    localparam int unsigned CntWidth   = 64;
    localparam logic [5:0]  CtrlAddr   = 6'h30;
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlverr = 2'b10;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;

    state_e                state_q;
    logic                  en_q;
    logic [AxiIdWidth-1:0] id_q;
    logic [5:0]            addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_q;
    logic                  first_q;
    logic                  not_ctrl_q;
    logic                  b_valid_q;
    logic [1:0]            b_resp_q;
    logic                  r_valid_q;
    logic [CntWidth-1:0]   rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;

    logic [CntWidth-1:0] cyc_q, aw_q, w_q, b_q, ar_q, rl_q;

    logic                aw_ev_c, w_ev_c, b_ev_c, ar_ev_c, rl_ev_c;
    logic                ctrl_wr_c, clr_c;
    logic [5:0]          rd_addr_c;
    logic [CntWidth-1:0] rd_data_c;
    logic                rd_err_c;
    logic                unused_c;

    assign snoop_req_o = snoop_req_i;
    assign snoop_rsp_o = snoop_rsp_i;
    assign unused_c    = ^cfg_req_i;

    // Handshake events on the observed bus and CTRL write strobes from the cfg port
    always_comb begin
        aw_ev_c   = snoop_req_i.aw_valid & snoop_rsp_i.aw_ready;
        w_ev_c    = snoop_req_i.w_valid & snoop_rsp_i.w_ready;
        b_ev_c    = snoop_rsp_i.b_valid & snoop_req_i.b_ready;
        ar_ev_c   = snoop_req_i.ar_valid & snoop_rsp_i.ar_ready;
        rl_ev_c   = snoop_rsp_i.r_valid & snoop_req_i.r_ready & snoop_rsp_i.r.last;
        ctrl_wr_c = (state_q == WDATA) & cfg_req_i.w_valid & first_q & ~not_ctrl_q
                    & cfg_req_i.w.strb[0];
        clr_c     = ctrl_wr_c & cfg_req_i.w.data[1];
    end

    // Register readout mux; the address comes from AR while idle, else from the capture
    always_comb begin
        rd_addr_c = (state_q == IDLE) ? cfg_req_i.ar.addr[5:0] : addr_q;
        rd_data_c = '0;
        rd_err_c  = 1'b0;
        if (rd_addr_c[2:0] != 3'd0) begin
            rd_err_c = 1'b1;
        end else begin
            case (rd_addr_c[5:3])
                3'd0:    rd_data_c = cyc_q;
                3'd1:    rd_data_c = aw_q;
                3'd2:    rd_data_c = w_q;
                3'd3:    rd_data_c = b_q;
                3'd4:    rd_data_c = ar_q;
                3'd5:    rd_data_c = rl_q;
                3'd6:    rd_data_c = CntWidth'(en_q);
                default: rd_err_c  = 1'b1;
            endcase
        end
    end

    // Event counters; a clear wins over any increment in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_q <= '0;
            aw_q  <= '0;
            w_q   <= '0;
            b_q   <= '0;
            ar_q  <= '0;
            rl_q  <= '0;
        end else if (clr_c) begin
            cyc_q <= '0;
            aw_q  <= '0;
            w_q   <= '0;
            b_q   <= '0;
            ar_q  <= '0;
            rl_q  <= '0;
        end else if (en_q) begin
            cyc_q <= cyc_q + CntWidth'(1);
            if (aw_ev_c) aw_q <= aw_q + CntWidth'(1);
            if (w_ev_c)  w_q  <= w_q + CntWidth'(1);
            if (b_ev_c)  b_q  <= b_q + CntWidth'(1);
            if (ar_ev_c) ar_q <= ar_q + CntWidth'(1);
            if (rl_ev_c) rl_q <= rl_q + CntWidth'(1);
        end
    end

    // Config-port responder FSM with registered B and R channels
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            en_q       <= 1'b1;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            first_q    <= 1'b0;
            not_ctrl_q <= 1'b1;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RespOkay;
            r_valid_q  <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RespOkay;
            rlast_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_req_i.aw_valid) begin
                        id_q       <= AxiIdWidth'(cfg_req_i.aw.id);
                        addr_q     <= cfg_req_i.aw.addr[5:0];
                        len_q      <= cfg_req_i.aw.len;
                        first_q    <= 1'b1;
                        not_ctrl_q <= (cfg_req_i.aw.addr[5:0] != CtrlAddr);
                        state_q    <= WDATA;
                    end else if (cfg_req_i.ar_valid) begin
                        id_q      <= AxiIdWidth'(cfg_req_i.ar.id);
                        addr_q    <= cfg_req_i.ar.addr[5:0];
                        len_q     <= cfg_req_i.ar.len;
                        beat_q    <= '0;
                        r_valid_q <= 1'b1;
                        rdata_q   <= rd_data_c;
                        rresp_q   <= (rd_err_c || cfg_req_i.ar.len != 8'd0) ? RespSlverr : RespOkay;
                        rlast_q   <= (cfg_req_i.ar.len == 8'd0);
                        state_q   <= RDATA;
                    end
                end
                WDATA: begin
                    if (cfg_req_i.w_valid) begin
                        first_q <= 1'b0;
                        if (ctrl_wr_c) en_q <= cfg_req_i.w.data[0];
                        if (cfg_req_i.w.last) begin
                            b_valid_q <= 1'b1;
                            b_resp_q  <= (not_ctrl_q || len_q != 8'd0) ? RespSlverr : RespOkay;
                            state_q   <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (cfg_req_i.b_ready) begin
                        b_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                RDATA: begin
                    if (cfg_req_i.r_ready) begin
                        if (rlast_q) begin
                            r_valid_q <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            rdata_q <= rd_data_c;
                            rlast_q <= ((beat_q + 8'd1) == len_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Assemble the cfg response; AW/AR readiness follows the state, writes win in IDLE
    always_comb begin
        cfg_rsp_o          = '0;
        cfg_rsp_o.aw_ready = (state_q == IDLE);
        cfg_rsp_o.ar_ready = (state_q == IDLE) & ~cfg_req_i.aw_valid;
        cfg_rsp_o.w_ready  = (state_q == WDATA);
        cfg_rsp_o.b_valid  = b_valid_q;
        cfg_rsp_o.b.id     = id_q;
        cfg_rsp_o.b.resp   = b_resp_q;
        cfg_rsp_o.r_valid  = r_valid_q;
        cfg_rsp_o.r.id     = id_q;
        cfg_rsp_o.r.data   = rdata_q;
        cfg_rsp_o.r.resp   = rresp_q;
        cfg_rsp_o.r.last   = rlast_q;
    end

endmodule

// File: tb/tb_axi_snoop_cnt_regs.sv
// Directed self-checking bench for axi_snoop_cnt_regs.
module tb_axi_snoop_cnt_regs;
    import axi_snoop_cnt_regs_pkg::*;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam int         TMO    = 50;

    logic     clk_i = 1'b0;
    logic     rst_ni;
    axi_req_t snoop_req, snoop_req_o_w, cfg_req;
    axi_rsp_t snoop_rsp, snoop_rsp_o_w, cfg_rsp;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [63:0] rd_data [4];
    logic [1:0]  rd_resp [4];
    logic        rd_last [4];
    logic [3:0]  rd_id;
    int          rd_beats;
    logic        rd_stable;
    logic [1:0]  wr_resp;
    logic [3:0]  wr_id;

    always #5 clk_i = ~clk_i;

    axi_snoop_cnt_regs #(
        .AxiIdWidth (4),
        .axi_req_t  (axi_req_t),
        .axi_rsp_t  (axi_rsp_t)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .snoop_req_i (snoop_req),
        .snoop_rsp_i (snoop_rsp),
        .snoop_req_o (snoop_req_o_w),
        .snoop_rsp_o (snoop_rsp_o_w),
        .cfg_req_i   (cfg_req),
        .cfg_rsp_o   (cfg_rsp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One snooped-bus cycle: bit4 aw, bit3 w, bit2 b, bit1 ar, bit0 r
    task automatic snoop_step(input logic [4:0] vld, input logic [4:0] rdy, input logic last);
        snoop_req.aw.addr   = $urandom;
        snoop_req.aw.id     = 4'($urandom);
        snoop_req.w.data    = {$urandom, $urandom};
        snoop_req.ar.addr   = $urandom;
        snoop_rsp.r.data    = {$urandom, $urandom};
        snoop_rsp.b.id      = 4'($urandom);
        snoop_req.aw_valid  = vld[4];
        snoop_rsp.aw_ready  = rdy[4];
        snoop_req.w_valid   = vld[3];
        snoop_rsp.w_ready   = rdy[3];
        snoop_rsp.b_valid   = vld[2];
        snoop_req.b_ready   = rdy[2];
        snoop_req.ar_valid  = vld[1];
        snoop_rsp.ar_ready  = rdy[1];
        snoop_rsp.r_valid   = vld[0];
        snoop_req.r_ready   = rdy[0];
        snoop_rsp.r.last    = last;
        #1;
        check("passthru_req", 64'(snoop_req_o_w === snoop_req), 64'd1);
        check("passthru_rsp", 64'(snoop_rsp_o_w === snoop_rsp), 64'd1);
        @(negedge clk_i);
    endtask

    task automatic cfg_write(input logic [31:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, input logic [3:0] id, input logic snoop_aw);
        int n;
        cfg_req.aw_valid = 1'b1;
        cfg_req.aw.addr  = addr;
        cfg_req.aw.len   = 8'd0;
        cfg_req.aw.id    = id;
        n = 0;
        #1;
        while (!cfg_rsp.aw_ready && n < TMO) begin @(negedge clk_i); #1; n++; end
        if (n >= TMO) check("aw_timeout", 64'(n), 64'd0);
        @(negedge clk_i);
        cfg_req.aw_valid = 1'b0;
        cfg_req.w_valid  = 1'b1;
        cfg_req.w.data   = data;
        cfg_req.w.strb   = strb;
        cfg_req.w.last   = 1'b1;
        if (snoop_aw) begin
            snoop_req.aw_valid = 1'b1;
            snoop_rsp.aw_ready = 1'b1;
        end
        n = 0;
        #1;
        while (!cfg_rsp.w_ready && n < TMO) begin @(negedge clk_i); #1; n++; end
        if (n >= TMO) check("w_timeout", 64'(n), 64'd0);
        @(negedge clk_i);
        snoop_req.aw_valid = 1'b0;
        snoop_rsp.aw_ready = 1'b0;
        cfg_req.w_valid    = 1'b0;
        cfg_req.w.last     = 1'b0;
        cfg_req.b_ready    = 1'b1;
        n = 0;
        #1;
        while (!cfg_rsp.b_valid && n < TMO) begin @(negedge clk_i); #1; n++; end
        if (n >= TMO) check("b_timeout", 64'(n), 64'd0);
        wr_resp = cfg_rsp.b.resp;
        wr_id   = cfg_rsp.b.id;
        @(negedge clk_i);
        cfg_req.b_ready = 1'b0;
    endtask

    task automatic cfg_read(input logic [31:0] addr, input logic [7:0] len,
                            input logic [3:0] id, input int stall);
        int n;
        logic [63:0] first;
        cfg_req.ar_valid = 1'b1;
        cfg_req.ar.addr  = addr;
        cfg_req.ar.len   = len;
        cfg_req.ar.id    = id;
        n = 0;
        #1;
        while (!cfg_rsp.ar_ready && n < TMO) begin @(negedge clk_i); #1; n++; end
        if (n >= TMO) check("ar_timeout", 64'(n), 64'd0);
        @(negedge clk_i);
        cfg_req.ar_valid = 1'b0;
        rd_beats  = 0;
        rd_stable = 1'b1;
        for (int b = 0; b <= int'(len) && b < 4; b++) begin
            n = 0;
            #1;
            while (!cfg_rsp.r_valid && n < TMO) begin @(negedge clk_i); #1; n++; end
            if (n >= TMO) begin
                check("r_timeout", 64'(n), 64'd0);
                break;
            end
            if (b == 0 && stall > 0) begin
                first = cfg_rsp.r.data;
                repeat (stall) begin
                    @(negedge clk_i);
                    #1;
                    if (cfg_rsp.r.data !== first || !cfg_rsp.r_valid) rd_stable = 1'b0;
                end
            end
            rd_data[b] = cfg_rsp.r.data;
            rd_resp[b] = cfg_rsp.r.resp;
            rd_last[b] = cfg_rsp.r.last;
            rd_id      = cfg_rsp.r.id;
            rd_beats++;
            cfg_req.r_ready = 1'b1;
            @(negedge clk_i);
            cfg_req.r_ready = 1'b0;
            if (rd_last[b]) break;
        end
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr,
                            input logic [63:0] exp_data, input logic [1:0] exp_resp);
        cfg_read(addr, 8'd0, 4'h1, 0);
        check(tag, rd_data[0], exp_data);
        check({tag, "_resp"}, 64'(rd_resp[0]), 64'(exp_resp));
    endtask

    initial begin
        rst_ni    = 1'b0;
        cfg_req   = '0;
        snoop_req = '0;
        snoop_rsp = '0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("rst_aw_ready", 64'(cfg_rsp.aw_ready), 64'd1);
        check("rst_ar_ready", 64'(cfg_rsp.ar_ready), 64'd1);
        check("rst_b_valid", 64'(cfg_rsp.b_valid), 64'd0);
        check("rst_r_valid", 64'(cfg_rsp.r_valid), 64'd0);
        @(negedge clk_i);

        // Idle, then read everything back
        repeat (100) @(negedge clk_i);
        cfg_read(32'h00, 8'd0, 4'h1, 0);
        check("cycles_ge_100", 64'(rd_data[0] >= 64'd100), 64'd1);
        check("cycles_resp", 64'(rd_resp[0]), 64'(OKAY));
        read_chk("rst_aw", 32'h08, 64'd0, OKAY);
        read_chk("rst_w", 32'h10, 64'd0, OKAY);
        read_chk("rst_b", 32'h18, 64'd0, OKAY);
        read_chk("rst_ar", 32'h20, 64'd0, OKAY);
        read_chk("rst_rl", 32'h28, 64'd0, OKAY);
        read_chk("rst_ctrl", 32'h30, 64'd1, OKAY);

        // Three single-beat writes with stalls
        for (int i = 0; i < 3; i++) begin
            snoop_step(5'b10000, 5'b00000, 1'b0);
            snoop_step(5'b10000, 5'b10000, 1'b0);
            snoop_step(5'b01000, 5'b00000, 1'b1);
            snoop_step(5'b01000, 5'b01000, 1'b1);
            snoop_step(5'b00100, 5'b00000, 1'b0);
            snoop_step(5'b00100, 5'b00100, 1'b0);
        end
        // Two four-beat reads with stalls
        for (int i = 0; i < 2; i++) begin
            snoop_step(5'b00010, 5'b00000, 1'b0);
            snoop_step(5'b00010, 5'b00010, 1'b0);
            snoop_step(5'b00001, 5'b00000, 1'b1);
            snoop_step(5'b00001, 5'b00001, 1'b0);
            snoop_step(5'b00001, 5'b00001, 1'b0);
            snoop_step(5'b00001, 5'b00001, 1'b0);
            snoop_step(5'b00001, 5'b00001, 1'b1);
        end
        snoop_step(5'b00000, 5'b00000, 1'b0);
        read_chk("traf_aw", 32'h08, 64'd3, OKAY);
        read_chk("traf_w", 32'h10, 64'd3, OKAY);
        read_chk("traf_b", 32'h18, 64'd3, OKAY);
        read_chk("traf_ar", 32'h20, 64'd2, OKAY);
        read_chk("traf_rl", 32'h28, 64'd2, OKAY);

        // Same-cycle AW, B and R-last
        snoop_step(5'b10101, 5'b10101, 1'b1);
        snoop_step(5'b00000, 5'b00000, 1'b0);
        read_chk("same_aw", 32'h08, 64'd4, OKAY);
        read_chk("same_w", 32'h10, 64'd3, OKAY);
        read_chk("same_b", 32'h18, 64'd4, OKAY);
        read_chk("same_ar", 32'h20, 64'd2, OKAY);
        read_chk("same_rl", 32'h28, 64'd3, OKAY);

        // Freeze
        cfg_write(32'h30, 64'h0, 8'hFF, 4'h7, 1'b0);
        check("freeze_resp", 64'(wr_resp), 64'(OKAY));
        check("freeze_bid", 64'(wr_id), 64'h7);
        repeat (3) snoop_step(5'b11111, 5'b11111, 1'b1);
        snoop_step(5'b00000, 5'b00000, 1'b0);
        read_chk("frz_aw", 32'h08, 64'd4, OKAY);
        read_chk("frz_w", 32'h10, 64'd3, OKAY);
        read_chk("frz_rl", 32'h28, 64'd3, OKAY);
        read_chk("frz_ctrl", 32'h30, 64'd0, OKAY);

        // Clear + enable with a simultaneous snooped AW
        cfg_write(32'h30, 64'h3, 8'hFF, 4'h2, 1'b1);
        check("clr_resp", 64'(wr_resp), 64'(OKAY));
        read_chk("clr_aw", 32'h08, 64'd0, OKAY);
        read_chk("clr_w", 32'h10, 64'd0, OKAY);
        read_chk("clr_ctrl", 32'h30, 64'd1, OKAY);
        snoop_step(5'b10000, 5'b10000, 1'b0);
        snoop_step(5'b00000, 5'b00000, 1'b0);
        read_chk("en_aw", 32'h08, 64'd1, OKAY);
        cfg_write(32'h30, 64'h3, 8'hFF, 4'h2, 1'b1);
        read_chk("clr2_aw", 32'h08, 64'd0, OKAY);

        // CTRL write without strobe on byte 0 has no effect
        cfg_write(32'h30, 64'h0, 8'hFE, 4'h3, 1'b0);
        check("nostrb_resp", 64'(wr_resp), 64'(OKAY));
        read_chk("nostrb_ctrl", 32'h30, 64'd1, OKAY);

        // Wrap from all-ones
        force dut.aw_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.aw_q;
        snoop_step(5'b10000, 5'b10000, 1'b0);
        snoop_step(5'b00000, 5'b00000, 1'b0);
        read_chk("wrap_aw", 32'h08, 64'd0, OKAY);

        // Error responses
        read_chk("unmapped", 32'h38, 64'd0, SLVERR);
        read_chk("misalign", 32'h0C, 64'd0, SLVERR);
        cfg_write(32'h08, 64'h55, 8'hFF, 4'h9, 1'b0);
        check("ro_wr_resp", 64'(wr_resp), 64'(SLVERR));
        check("ro_wr_bid", 64'(wr_id), 64'h9);
        read_chk("ro_wr_aw", 32'h08, 64'd0, OKAY);
        cfg_read(32'h00, 8'd1, 4'hA, 5);
        check("burst_beats", 64'(rd_beats), 64'd2);
        check("burst_last0", 64'(rd_last[0]), 64'd0);
        check("burst_last1", 64'(rd_last[1]), 64'd1);
        check("burst_resp0", 64'(rd_resp[0]), 64'(SLVERR));
        check("burst_resp1", 64'(rd_resp[1]), 64'(SLVERR));
        check("burst_stable", 64'(rd_stable), 64'd1);
        check("burst_rid", 64'(rd_id), 64'hA);

        // Simultaneous AW and AR in IDLE: write first
        cfg_req.aw_valid = 1'b1;
        cfg_req.aw.addr  = 32'h30;
        cfg_req.aw.len   = 8'd0;
        cfg_req.aw.id    = 4'h2;
        cfg_req.ar_valid = 1'b1;
        cfg_req.ar.addr  = 32'h30;
        cfg_req.ar.len   = 8'd0;
        cfg_req.ar.id    = 4'h3;
        #1;
        check("prio_aw_ready", 64'(cfg_rsp.aw_ready), 64'd1);
        check("prio_ar_ready", 64'(cfg_rsp.ar_ready), 64'd0);
        @(negedge clk_i);
        cfg_req.aw_valid = 1'b0;
        cfg_req.w_valid  = 1'b1;
        cfg_req.w.data   = 64'h1;
        cfg_req.w.strb   = 8'h01;
        cfg_req.w.last   = 1'b1;
        #1;
        check("prio_w_ready", 64'(cfg_rsp.w_ready), 64'd1);
        check("prio_ar_blocked", 64'(cfg_rsp.ar_ready), 64'd0);
        @(negedge clk_i);
        cfg_req.w_valid = 1'b0;
        cfg_req.w.last  = 1'b0;
        cfg_req.b_ready = 1'b1;
        #1;
        check("prio_b_valid", 64'(cfg_rsp.b_valid), 64'd1);
        check("prio_b_id", 64'(cfg_rsp.b.id), 64'h2);
        check("prio_r_idle", 64'(cfg_rsp.r_valid), 64'd0);
        @(negedge clk_i);
        cfg_req.b_ready = 1'b0;
        #1;
        check("prio_ar_now", 64'(cfg_rsp.ar_ready), 64'd1);
        @(negedge clk_i);
        cfg_req.ar_valid = 1'b0;
        #1;
        check("prio_r_valid", 64'(cfg_rsp.r_valid), 64'd1);
        check("prio_r_id", 64'(cfg_rsp.r.id), 64'h3);
        check("prio_r_data", cfg_rsp.r.data, 64'h1);
        cfg_req.r_ready = 1'b1;
        @(negedge clk_i);
        cfg_req.r_ready = 1'b0;

        // Reset during a write aborts it
        cfg_req.aw_valid = 1'b1;
        cfg_req.aw.addr  = 32'h30;
        cfg_req.aw.id    = 4'h4;
        @(negedge clk_i);
        cfg_req.aw_valid = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("abort_b_valid", 64'(cfg_rsp.b_valid), 64'd0);
        @(negedge clk_i);
        rst_ni          = 1'b1;
        cfg_req.w_valid = 1'b1;
        cfg_req.w.last  = 1'b1;
        cfg_req.w.data  = 64'h0;
        cfg_req.w.strb  = 8'hFF;
        cfg_req.b_ready = 1'b1;
        #1;
        check("abort_w_ready", 64'(cfg_rsp.w_ready), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        check("abort_no_b", 64'(cfg_rsp.b_valid), 64'd0);
        cfg_req.w_valid = 1'b0;
        cfg_req.w.last  = 1'b0;
        cfg_req.b_ready = 1'b0;
        @(negedge clk_i);
        read_chk("abort_ctrl", 32'h30, 64'd1, OKAY);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
